// File: rtl/pkt_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_stat_pkg
// Purpose  : Shared constants and types for the multi-port packet statistics
//            block: flit type codes, TSN class codes, counter indices, CTRL
//            register layout and the per-port address stride.
// Ports    : none (package)
// Options  : STAT_CLR_ON_READ_EN (consumed by pkt_stat_multi)
// Revision : 1.0 - initial release
// ============================================================================
package pkt_stat_pkg;

  // Flit type field, data[133:132]
  localparam logic [1:0] c_FLIT_INV  = 2'b00;  // handled like a middle flit
  localparam logic [1:0] c_FLIT_HEAD = 2'b01;
  localparam logic [1:0] c_FLIT_TAIL = 2'b10;
  localparam logic [1:0] c_FLIT_MID  = 2'b11;

  // Class field of the head flit
  localparam logic [1:0] c_CLS_TS  = 2'b00;
  localparam logic [1:0] c_CLS_RC  = 2'b01;
  localparam logic [1:0] c_CLS_BE  = 2'b10;
  localparam logic [1:0] c_CLS_UNK = 2'b11;

  // Counter indices inside one port's register block
  localparam logic [2:0] c_IDX_TS          = 3'd0;
  localparam logic [2:0] c_IDX_RC          = 3'd1;
  localparam logic [2:0] c_IDX_BE          = 3'd2;
  localparam logic [2:0] c_IDX_UNK         = 3'd3;
  localparam logic [2:0] c_IDX_ERR         = 3'd4;
  localparam logic [2:0] c_IDX_TS_INTERVAL = 3'd5;
  localparam int         c_NUM_CNT         = 6;

  // CTRL register
  localparam logic [11:0] c_CTRL_OFFSET     = 12'h800;
  localparam int          c_CTRL_CLEAR_BIT  = 0;
  localparam int          c_CTRL_FREEZE_BIT = 1;

  // Each port owns a 64-byte block: addr = base + (port << 6) + (idx << 2)
  localparam int c_PORT_STRIDE_SHIFT = 6;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_INPKT = 1'b1
  } port_state_e;

endpackage : pkt_stat_pkg
`default_nettype wire

// File: rtl/pkt_stat_port.sv
`default_nettype none
// ============================================================================
// Module   : pkt_stat_port
// Purpose  : Statistics engine for one snooped pktout bus. Tracks packet
//            framing, counts completed packets per class plus malformed
//            flits, and measures the TS head inter-arrival interval.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_data[133:0]    - snooped flit
//            i_wr             - flit strobe
//            i_clear          - zero all counters and the interval timer
//            i_freeze         - hold counters (framing keeps tracking)
//            i_rd_clr         - zero the counter selected by i_rd_idx
//            i_rd_idx[2:0]    - read select
//            o_rd_data        - selected counter, 0 for idx > 5
// Revision : 1.0 - initial release
// ============================================================================
module pkt_stat_port #(
  parameter int CNT_W  = 32,
  parameter int CLS_HI = 111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [133:0]     i_data,
  input  logic             i_wr,
  input  logic             i_clear,
  input  logic             i_freeze,
  input  logic             i_rd_clr,
  input  logic [2:0]       i_rd_idx,
  output logic [CNT_W-1:0] o_rd_data
);
  import pkt_stat_pkg::*;

  localparam logic [CNT_W-1:0] c_MAX = '1;

  port_state_e      r_state;
  port_state_e      w_state_nxt;
  logic [1:0]       r_cls;
  logic [1:0]       w_type;
  logic [1:0]       w_cls_in;
  logic             w_latch;
  logic             w_done;
  logic             w_err;
  logic [4:0]       w_inc;
  logic [4:0][CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_interval;
  logic [CNT_W-1:0] r_timer;
  logic             w_ts_head;
  logic             w_int_upd;
  logic             w_unused;

  assign w_type   = i_data[133:132];
  assign w_cls_in = i_data[CLS_HI -: 2];
  assign w_unused = &{1'b0, i_data};

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cls   <= c_CLS_TS;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_cls <= w_cls_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (i_wr) begin
      case (r_state)
        ST_IDLE: begin
          if (w_type == c_FLIT_HEAD) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_INPKT;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_INPKT: begin
          if (w_type == c_FLIT_HEAD) begin
            // Aborted packet: flag it and restart on the new head
            w_err   = 1'b1;
            w_latch = 1'b1;
          end else if (w_type == c_FLIT_TAIL) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_inc[c_IDX_TS]  = w_done && (r_cls == c_CLS_TS);
  assign w_inc[c_IDX_RC]  = w_done && (r_cls == c_CLS_RC);
  assign w_inc[c_IDX_BE]  = w_done && (r_cls == c_CLS_BE);
  assign w_inc[c_IDX_UNK] = w_done && (r_cls == c_CLS_UNK);
  assign w_inc[c_IDX_ERR] = w_err;

  // --------------------------------------------------------------------------
  // Event counters: clear beats freeze beats increment. A read-clear that
  // coincides with an increment leaves 1 so the event is not lost.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst || i_clear) begin
        r_cnt[i] <= '0;
      end else if (i_rd_clr && (i_rd_idx == 3'(i))) begin
        r_cnt[i] <= (w_inc[i] && !i_freeze) ? CNT_W'(1) : '0;
      end else if (w_inc[i] && !i_freeze && (r_cnt[i] != c_MAX)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TS inter-arrival: timer==0 means "not armed"; once armed it never returns
  // to 0 (saturates) until a clear, so no separate armed flag is needed.
  // --------------------------------------------------------------------------
  assign w_ts_head = i_wr && (w_type == c_FLIT_HEAD) && (w_cls_in == c_CLS_TS);
  assign w_int_upd = w_ts_head && (r_timer != '0) && !i_freeze;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_timer <= '0;
    end else if (w_ts_head) begin
      r_timer <= CNT_W'(1);
    end else if ((r_timer != '0) && (r_timer != c_MAX)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_interval <= '0;
    end else if (i_rd_clr && (i_rd_idx == c_IDX_TS_INTERVAL)) begin
      r_interval <= w_int_upd ? r_timer : '0;
    end else if (w_int_upd) begin
      r_interval <= r_timer;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    o_rd_data = '0;
    case (i_rd_idx)
      c_IDX_TS, c_IDX_RC, c_IDX_BE, c_IDX_UNK, c_IDX_ERR:
        o_rd_data = r_cnt[i_rd_idx];
      c_IDX_TS_INTERVAL:
        o_rd_data = r_interval;
      default:
        o_rd_data = '0;
    endcase
  end

endmodule : pkt_stat_port
`default_nettype wire

// File: rtl/pkt_stat_multi.sv
`default_nettype none
// ============================================================================
// Module   : pkt_stat_multi
// Purpose  : Passive statistics snooper for NUM_PORTS 134-bit pktout buses
//            with cfg-bus access to per-port counters and a CTRL register.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_pkt_data       - NUM_PORTS flits, port p at [p*134 +: 134]
//            in_pkt_data_wr    - per-port flit strobe
//            cfg_cs_n, cfg_rw  - chip select (low), 0 write / 1 read
//            cfg_addr, cfg_wdata
//            cfg_ack_n         - one-cycle low acknowledge
//            cfg_rdata         - read data, valid with the acknowledge
// Options  : STAT_CLR_ON_READ_EN - counter reads are destructive
// Revision : 1.0 - initial release
// ============================================================================
module pkt_stat_multi #(
  parameter int          NUM_PORTS = 4,
  parameter int          CNT_W     = 32,
  parameter int          CLS_HI    = 111,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS*134-1:0] in_pkt_data,
  input  logic [NUM_PORTS-1:0]     in_pkt_data_wr,
  input  logic                     cfg_cs_n,
  input  logic                     cfg_rw,
  input  logic [31:0]              cfg_addr,
  input  logic [31:0]              cfg_wdata,
  output logic                     cfg_ack_n,
  output logic [31:0]              cfg_rdata
);
  import pkt_stat_pkg::*;

  logic                 r_busy;
  logic                 r_ack_n;
  logic [31:0]          r_rdata;
  logic                 r_freeze;

  logic                 w_start;
  logic                 w_in_win;
  logic [3:0]           w_sel;
  logic [3:0]           w_idx;
  logic                 w_port_ok;
  logic                 w_cnt_hit;
  logic                 w_ctrl_hit;
  logic                 w_acc;
  logic                 w_rd_hit;
  logic                 w_ctrl_wr;
  logic                 w_clear;
  logic [31:0]          w_rd_val;
  logic [NUM_PORTS-1:0] w_rd_clr;
  logic [CNT_W-1:0]     w_port_rd [NUM_PORTS];
  logic                 w_unused;

  assign w_unused = &{1'b0, cfg_wdata[31:2]};

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_in_win   = (cfg_addr[31:12] == BASE_ADDR[31:12]);
  assign w_sel      = cfg_addr[c_PORT_STRIDE_SHIFT +: 4];
  assign w_idx      = cfg_addr[5:2];
  assign w_port_ok  = ({28'd0, w_sel} < 32'(NUM_PORTS));
  assign w_cnt_hit  = w_in_win && (cfg_addr[11:10] == 2'b00) &&
                      (cfg_addr[1:0] == 2'b00) && (w_idx < 4'd6) && w_port_ok;
  assign w_ctrl_hit = w_in_win && (cfg_addr[11:0] == c_CTRL_OFFSET);

  // A transaction is accepted once per cs_n low period; everything that
  // modifies state happens on that accepting edge so its effect is already
  // visible during the acknowledge cycle.
  assign w_start   = !cfg_cs_n && !r_busy;
  assign w_acc     = w_start && w_in_win;
  assign w_rd_hit  = w_acc && cfg_rw && w_cnt_hit;
  assign w_ctrl_wr = w_acc && !cfg_rw && w_ctrl_hit;
  assign w_clear   = w_ctrl_wr && cfg_wdata[c_CTRL_CLEAR_BIT];

  // --------------------------------------------------------------------------
  // Per-port engines
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
`ifdef STAT_CLR_ON_READ_EN
    assign w_rd_clr[g] = w_rd_hit && (w_sel == 4'(g));
`else
    assign w_rd_clr[g] = 1'b0;
`endif

    pkt_stat_port #(
      .CNT_W  (CNT_W),
      .CLS_HI (CLS_HI)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .i_data    (in_pkt_data[g*134 +: 134]),
      .i_wr      (in_pkt_data_wr[g]),
      .i_clear   (w_clear),
      .i_freeze  (r_freeze),
      .i_rd_clr  (w_rd_clr[g]),
      .i_rd_idx  (w_idx[2:0]),
      .o_rd_data (w_port_rd[g])
    );
  end

  // --------------------------------------------------------------------------
  // Read data select
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_val = '0;
    if (w_ctrl_hit) begin
      w_rd_val[c_CTRL_FREEZE_BIT] = r_freeze;  // CLEAR always reads 0
    end else if (w_cnt_hit) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_sel == 4'(p)) w_rd_val = 32'(w_port_rd[p]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and CTRL register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_ack_n  <= 1'b1;
      r_rdata  <= '0;
      r_freeze <= 1'b0;
    end else begin
      if (w_start)       r_busy <= 1'b1;
      else if (cfg_cs_n) r_busy <= 1'b0;

      // Out-of-window accesses are swallowed without an acknowledge
      r_ack_n <= !w_acc;
      r_rdata <= (w_acc && cfg_rw) ? w_rd_val : 32'd0;

      if (w_ctrl_wr) r_freeze <= cfg_wdata[c_CTRL_FREEZE_BIT];
    end
  end

  assign cfg_ack_n = r_ack_n;
  assign cfg_rdata = r_rdata;

endmodule : pkt_stat_multi
`default_nettype wire
